ddr2_app_responder: RTL
=======================

DDR2_APP_RESPONDER -- requirements
Module: ddr2_app_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: log2 of memory depth in 256-bit words.
REQ-002 SHALL have parameter INIT_CYCLES, default 16: cycles from reset release to phy_init_done.
REQ-003 SHALL have parameter AF_DEPTH, default 4: command FIFO depth; WDF_DEPTH, default 8: write-data FIFO depth.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does:
  - CLK  in  1  clock
  - RST  in  1  reset
REQ-005 SHALL have these ports:
  - phy_init_done  out  1  initialisation complete
  - app_af_wren  in  1  command push
  - app_af_addr  in  31  command address
  - app_af_read  in  1  1=read, 0=write
  - app_af_afull  out  1  command FIFO almost full
  - app_wdf_wren  in  1  write-data push
  - app_wdf_data  in  128  write beat
  - app_wdf_mask_data  in  16  byte mask, 1=byte not written
  - app_wdf_afull  out  1  write-data FIFO almost full
  - rd_data_valid  out  1  read beat valid
  - rd_data_fifo_out  out  128  read beat
  - err_overflow  out  1  sticky protocol error

Function
REQ-006 SHALL count INIT_CYCLES cycles after reset release, then hold phy_init_done at 1 until the next reset.
REQ-007 SHALL drop all pushes while phy_init_done=0.
REQ-008 SHALL accept a command or data push only if the FIFO's occupancy before the edge is below its depth; otherwise drop it, even if a pop occurs in the same cycle.
REQ-009 SHALL drive app_af_afull=1 when command occupancy >= AF_DEPTH-1, and app_wdf_afull=1 when data occupancy >= WDF_DEPTH-2; both are registered from occupancy.
REQ-010 SHALL model memory as 2^ADDR_W words of 256 bits, indexed by app_af_addr[ADDR_W+1:2]; higher address bits and addr[1:0] SHALL be ignored, so addresses wrap modulo the depth.
REQ-011 SHALL run an engine FSM with states IDLE, WR1, WR2, RD1, RD2, leaving reset in IDLE.
REQ-012 IDLE: head is a read -> pop it, go to RD1.
REQ-013 IDLE: head is a write and data occupancy >= 2 -> pop it, go to WR1.
REQ-014 IDLE: otherwise stay in IDLE, including a write head with fewer than 2 data beats.
REQ-015 WR1 SHALL pop one data beat and write it into bits [255:128] under its mask, then go to WR2.
REQ-016 WR2 SHALL pop one data beat, write it into bits [127:0] under its mask, then return to IDLE.
REQ-017 Read path:
  - RD1: go to RD2 unconditionally.
  - RD2: return to IDLE.
  - rd_data_valid SHALL be 1 for exactly two consecutive cycles, the first being 2 cycles after the IDLE pop edge.
  - Beat 1 SHALL be bits [255:128]; beat 2 SHALL be bits [127:0].
REQ-018 SHALL read the memory after any completed write to the same word, giving read-after-write ordering by command order.
REQ-019 SHALL hold rd_data_fifo_out at its last value when rd_data_valid=0.
REQ-020 SHALL have no backpressure on the read return path.

Reset
REQ-021 While RST=1, SHALL drive:
  - phy_init_done=0, both afull=1, rd_data_valid=0, rd_data_fifo_out=0, err_overflow=0
  - FSM=IDLE, FIFOs empty, init counter=0
REQ-022 SHALL discard any in-flight command or beat when reset is asserted mid-operation.
REQ-023 SHALL leave memory contents unchanged across reset.

Configuration
REQ-024 With macro DDR2_APP_RESPONDER_CHECK_EN defined, err_overflow SHALL set and stay set until reset on any of:
  - a dropped push (REQ-007, REQ-008);
  - a data push while data occupancy >= 2 x (queued write commands) + 2.
REQ-025 Without DDR2_APP_RESPONDER_CHECK_EN, err_overflow SHALL be constant 0 and no checking logic SHALL be present.

Verification
REQ-026 Initialisation: release reset, INIT_CYCLES=16 -> phy_init_done rises after 16 cycles; a push at cycle 10 is dropped and err_overflow=1 with check enabled.
REQ-027 Write then read: write to addr 0x8, beats 0xAA..A/0x55..5, mask 0 -> read of addr 0x8 returns 0xAA..A then 0x55..5 on consecutive cycles, 2 cycles after pop.
REQ-028 Masked write: write to addr 0x8, mask 0xFFFE on beat 1 -> only byte 0 of the upper half changes; a subsequent read confirms.
REQ-029 Full FIFO: 5 command pushes with the engine stalled (no data) -> app_af_afull=1 after 3; the 5th is dropped; err_overflow=1.
REQ-030 Wrap: ADDR_W=8, write to addr 0x400 -> data readable at addr 0x0.
REQ-031 Mid-burst reset: assert RST during RD1 -> no rd_data_valid follows; phy_init_done re-sequences; memory data is intact.

Source files
------------

// File: rtl/ddr2_app_responder_if.sv
// Application-side bus of the DDR2 responder: command FIFO, write-data FIFO and read return.
interface ddr2_app_responder_if;
    logic         phy_init_done;
    logic         app_af_wren;
    logic [30:0]  app_af_addr;
    logic         app_af_read;
    logic         app_af_afull;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask_data;
    logic         app_wdf_afull;
    logic         rd_data_valid;
    logic [127:0] rd_data_fifo_out;
    logic         err_overflow;

    modport master (
        input  phy_init_done, app_af_afull, app_wdf_afull,
        input  rd_data_valid, rd_data_fifo_out, err_overflow,
        output app_af_wren, app_af_addr, app_af_read,
        output app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );

    modport slave (
        output phy_init_done, app_af_afull, app_wdf_afull,
        output rd_data_valid, rd_data_fifo_out, err_overflow,
        input  app_af_wren, app_af_addr, app_af_read,
        input  app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );
endinterface

// File: rtl/ddr2_app_responder.sv
// Behavioural DDR2 controller responder: init delay, command/data FIFOs, 256-bit memory, 2-beat bursts.
// Optional protocol checker enabled by defining DDR2_APP_RESPONDER_CHECK_EN.
module ddr2_app_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned AF_DEPTH    = 4,
    parameter int unsigned WDF_DEPTH   = 8
) (
    input logic                  CLK,
    input logic                  RST,
    ddr2_app_responder_if.slave  app
);
    localparam int unsigned AF_PW     = (AF_DEPTH > 1) ? $clog2(AF_DEPTH) : 1;
    localparam int unsigned AF_CW     = $clog2(AF_DEPTH + 1);
    localparam int unsigned WDF_PW    = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
    localparam int unsigned WDF_CW    = $clog2(WDF_DEPTH + 1);
    localparam int unsigned INIT_W    = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2} state_t;

    state_t              state;
    logic [INIT_W-1:0]   init_cnt;
    logic                init_done;
    logic                af_afull_q, wdf_afull_q;
    logic                rd_valid_q, rd_pend;
    logic [127:0]        rd_data_q, rd_hold;
    logic [ADDR_W-1:0]   cur_idx;

    logic [ADDR_W-1:0]   af_addr_q [AF_DEPTH];
    logic                af_read_q [AF_DEPTH];
    logic [AF_PW-1:0]    af_wr_ptr, af_rd_ptr;
    logic [AF_CW-1:0]    af_cnt, af_cnt_nxt;
    logic [127:0]        wdf_data_q [WDF_DEPTH];
    logic [15:0]         wdf_mask_q [WDF_DEPTH];
    logic [WDF_PW-1:0]   wdf_wr_ptr, wdf_rd_ptr;
    logic [WDF_CW-1:0]   wdf_cnt, wdf_cnt_nxt;
    logic [255:0]        mem [MEM_DEPTH];

    logic                af_push, af_pop, af_head_read;
    logic                wdf_push, wdf_pop;
    logic [127:0]        wdf_head_data;
    logic [15:0]         wdf_head_mask;
    logic [255:0]        rd_word, wr_word;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{app.app_af_addr[30:ADDR_W+2], app.app_af_addr[1:0]};

    // FIFO handshakes and the byte-merged word for the current write beat
    always_comb begin
        af_head_read  = af_read_q[af_rd_ptr];
        wdf_head_data = wdf_data_q[wdf_rd_ptr];
        wdf_head_mask = wdf_mask_q[wdf_rd_ptr];
        af_push  = app.app_af_wren && init_done && (af_cnt < AF_CW'(AF_DEPTH));
        wdf_push = app.app_wdf_wren && init_done && (wdf_cnt < WDF_CW'(WDF_DEPTH));
        af_pop   = (state == IDLE) && (af_cnt != '0) &&
                   (af_head_read || (wdf_cnt >= WDF_CW'(2)));
        wdf_pop  = (state == WR1) || (state == WR2);
        af_cnt_nxt  = af_cnt + AF_CW'(af_push) - AF_CW'(af_pop);
        wdf_cnt_nxt = wdf_cnt + WDF_CW'(wdf_push) - WDF_CW'(wdf_pop);
        rd_word = mem[cur_idx];
        wr_word = rd_word;
        for (int b = 0; b < 16; b++) begin
            if (!wdf_head_mask[b]) begin
                if (state == WR1) wr_word[128 + 8*b +: 8] = wdf_head_data[8*b +: 8];
                else              wr_word[8*b +: 8]       = wdf_head_data[8*b +: 8];
            end
        end
    end

    // Storage without reset: FIFO slots and memory survive RST
    always_ff @(posedge CLK) begin
        if (af_push) begin
            af_addr_q[af_wr_ptr] <= app.app_af_addr[ADDR_W+1:2];
            af_read_q[af_wr_ptr] <= app.app_af_read;
        end
        if (wdf_push) begin
            wdf_data_q[wdf_wr_ptr] <= app.app_wdf_data;
            wdf_mask_q[wdf_wr_ptr] <= app.app_wdf_mask_data;
        end
        if (wdf_pop) mem[cur_idx] <= wr_word;
    end

    // Init sequencer, FIFO pointers and burst engine
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            init_cnt    <= '0;
            init_done   <= 1'b0;
            af_afull_q  <= 1'b1;
            wdf_afull_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_pend     <= 1'b0;
            rd_data_q   <= '0;
            rd_hold     <= '0;
            cur_idx     <= '0;
            af_wr_ptr   <= '0;
            af_rd_ptr   <= '0;
            af_cnt      <= '0;
            wdf_wr_ptr  <= '0;
            wdf_rd_ptr  <= '0;
            wdf_cnt     <= '0;
        end else begin
            if (!init_done) begin
                if (init_cnt == INIT_W'(INIT_CYCLES - 1)) init_done <= 1'b1;
                else                                      init_cnt  <= init_cnt + 1'b1;
            end

            af_cnt      <= af_cnt_nxt;
            wdf_cnt     <= wdf_cnt_nxt;
            af_afull_q  <= af_cnt_nxt >= AF_CW'(AF_DEPTH - 1);
            wdf_afull_q <= wdf_cnt_nxt >= WDF_CW'(WDF_DEPTH - 2);
            if (af_push)
                af_wr_ptr <= (af_wr_ptr == AF_PW'(AF_DEPTH - 1)) ? '0 : af_wr_ptr + 1'b1;
            if (af_pop)
                af_rd_ptr <= (af_rd_ptr == AF_PW'(AF_DEPTH - 1)) ? '0 : af_rd_ptr + 1'b1;
            if (wdf_push)
                wdf_wr_ptr <= (wdf_wr_ptr == WDF_PW'(WDF_DEPTH - 1)) ? '0 : wdf_wr_ptr + 1'b1;
            if (wdf_pop)
                wdf_rd_ptr <= (wdf_rd_ptr == WDF_PW'(WDF_DEPTH - 1)) ? '0 : wdf_rd_ptr + 1'b1;

            rd_valid_q <= 1'b0;
            if (rd_pend) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= rd_hold;
                rd_pend    <= 1'b0;
            end

            case (state)
                IDLE: if (af_pop) begin
                    cur_idx <= af_addr_q[af_rd_ptr];
                    state   <= af_head_read ? RD1 : WR1;
                end
                WR1: state <= WR2;
                WR2: state <= IDLE;
                RD1: state <= RD2;
                // Whole word captured here; lower half goes out on the following cycle
                RD2: begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rd_word[255:128];
                    rd_hold    <= rd_word[127:0];
                    rd_pend    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign app.phy_init_done    = init_done;
    assign app.app_af_afull     = af_afull_q;
    assign app.app_wdf_afull    = wdf_afull_q;
    assign app.rd_data_valid    = rd_valid_q;
    assign app.rd_data_fifo_out = rd_data_q;

`ifdef DDR2_APP_RESPONDER_CHECK_EN
    logic [AF_CW-1:0] af_wr_cnt;
    logic [1:0]       inflight_beats;
    logic             err_q, excess_push;

    // Beats still owed to queued writes plus the write the engine is executing
    always_comb begin
        inflight_beats = (state == WR1) ? 2'd2 : (state == WR2) ? 2'd1 : 2'd0;
        excess_push = app.app_wdf_wren &&
                      (32'(wdf_cnt) >= 32'(af_wr_cnt) * 32'd2 + 32'(inflight_beats) + 32'd2);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            af_wr_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            af_wr_cnt <= af_wr_cnt + AF_CW'(af_push && !app.app_af_read)
                                   - AF_CW'(af_pop && !af_head_read);
            if ((app.app_af_wren && !af_push) || (app.app_wdf_wren && !wdf_push) || excess_push)
                err_q <= 1'b1;
        end
    end

    assign app.err_overflow = err_q;
`else
    assign app.err_overflow = 1'b0;
`endif
endmodule
